// File: rtl/l_preamble_gen_pkg.sv
// Shared constants, types and helpers for the legacy 802.11a/g preamble generator.
// IQ words carry I in [31:16] and Q in [15:0], each a signed 16-bit value.
package l_preamble_gen_pkg;

  localparam int unsigned STF_LEN = 16;
  localparam int unsigned LTF_LEN = 64;

  typedef logic [15:0] comp_t;
  typedef logic [31:0] iq_t;

  typedef enum logic [1:0] {
    StIdle,
    StStf,
    StLtfGi,
    StLtfSym
  } state_e;

  function automatic iq_t iq_pack(input comp_t i, input comp_t q);
    return {i, q};
  endfunction

endpackage

// File: rtl/l_preamble_gen_if.sv
// Valid/ready IQ sample stream from the preamble generator to the sample mux.
interface l_preamble_gen_if;
  import l_preamble_gen_pkg::*;

  iq_t  iq;
  logic iq_valid;
  logic iq_ready;

  modport master (output iq, output iq_valid, input iq_ready);
  modport slave  (input iq, input iq_valid, output iq_ready);

endinterface

// File: rtl/l_win_avg.sv
// Per-component edge window: floor((a + b) / 2) on signed 16-bit values.
// Halving a single sample is the same operation with b tied to zero.
module l_win_avg
  import l_preamble_gen_pkg::*;
(
  input  comp_t a,
  input  comp_t b,
  output comp_t y
);

  logic signed [16:0] sum;

  assign sum = $signed({a[15], a}) + $signed({b[15], b});
  assign y   = 16'(sum >>> 1);

endmodule

// File: rtl/l_preamble_gen.sv
// Streams the L-STF then L-LTF (guard interval plus two symbols) from external ROMs
// into a registered valid/ready IQ output, with optional windowing at the region edges.
module l_preamble_gen
  import l_preamble_gen_pkg::*;
#(
  parameter bit          WINDOW_EN  = 1'b1,
  parameter int unsigned STF_REPS   = 10,
  parameter int unsigned LTF_GI_LEN = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  output logic [3:0]              stf_addr,
  input  iq_t                     stf_dout,
  output logic [5:0]              ltf_addr,
  input  iq_t                     ltf_dout,
  l_preamble_gen_if.master        tx,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned StfTot = STF_LEN * STF_REPS;
  localparam int unsigned GiEnd  = StfTot + LTF_GI_LEN;
  localparam int unsigned NTot   = GiEnd + 2 * LTF_LEN;
  localparam int unsigned NW     = $clog2(NTot);

  typedef logic [NW-1:0] idx_t;

  localparam idx_t       StfTotI  = idx_t'(StfTot);
  localparam idx_t       GiEndI   = idx_t'(GiEnd);
  localparam idx_t       StfLast  = idx_t'(StfTot - 1);
  localparam idx_t       GiLast   = idx_t'(GiEnd - 1);
  localparam idx_t       NLast    = idx_t'(NTot - 1);
  localparam logic [5:0] LtfGiOfs = 6'(LTF_LEN - LTF_GI_LEN);

  state_e state_q, state_d;
  idx_t   n_q, n_d;
  iq_t    iq_q, iq_d;
  logic   iq_valid_q, iq_valid_d;
  logic   done_q, done_d;
  logic   start_acc, load;
  logic   win_edge, win_sel;
  comp_t  win_b_i, win_b_q, win_i, win_q;
  iq_t    sample;

  // Both ROM addresses are driven every cycle; at the STF->LTF edge stf_addr rests at 0,
  // which is exactly the STF word the boundary average needs.
  always_comb begin
    stf_addr = '0;
    ltf_addr = '0;
    if (n_q < StfTotI) begin
      stf_addr = n_q[3:0];
    end else if (n_q < GiEndI) begin
      ltf_addr = 6'(n_q - StfTotI) + LtfGiOfs;
    end else begin
      ltf_addr = 6'(n_q - GiEndI);
    end
  end

  assign win_edge = (n_q == StfTotI);
  assign win_sel  = WINDOW_EN && ((n_q == '0) || win_edge);
  assign win_b_i  = win_edge ? ltf_dout[31:16] : '0;
  assign win_b_q  = win_edge ? ltf_dout[15:0]  : '0;

  l_win_avg u_win_i (
    .a (stf_dout[31:16]),
    .b (win_b_i),
    .y (win_i)
  );

  l_win_avg u_win_q (
    .a (stf_dout[15:0]),
    .b (win_b_q),
    .y (win_q)
  );

  assign sample = win_sel ? iq_pack(win_i, win_q) : ((n_q < StfTotI) ? stf_dout : ltf_dout);

  // A start is honoured only once the previous preamble's last sample has drained.
  assign start_acc = start && (state_q == StIdle) && !iq_valid_q;
  assign load      = ((state_q != StIdle) || start_acc) && (!iq_valid_q || tx.iq_ready);
  assign busy      = (state_q != StIdle) || iq_valid_q || start_acc;

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    iq_d       = iq_q;
    iq_valid_d = iq_valid_q;
    done_d     = 1'b0;
    if (load) begin
      iq_d       = sample;
      iq_valid_d = 1'b1;
      n_d        = (n_q == NLast) ? '0 : n_q + 1'b1;
      unique case (state_q)
        StIdle:   state_d = StStf;
        StStf:    if (n_q == StfLast) state_d = StLtfGi;
        StLtfGi:  if (n_q == GiLast)  state_d = StLtfSym;
        StLtfSym: if (n_q == NLast)   state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end else if (iq_valid_q && tx.iq_ready) begin
      iq_valid_d = 1'b0;
      done_d     = (state_q == StIdle);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StIdle;
      n_q        <= '0;
      iq_q       <= '0;
      iq_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      iq_q       <= iq_d;
      iq_valid_q <= iq_valid_d;
      done_q     <= done_d;
    end
  end

  assign tx.iq       = iq_q;
  assign tx.iq_valid = iq_valid_q;
  assign done        = done_q;

endmodule

// File: tb/tb_l_preamble_gen.sv
// Bench for l_preamble_gen: a windowed and an unwindowed instance share stimulus and are
// checked every cycle against a sample-index model of the preamble stream.
module tb_l_preamble_gen;

  localparam int NTOT = 320;

  logic clk = 1'b0;
  logic rstn, start, ready;

  logic [31:0] stf_rom [16];
  logic [31:0] ltf_rom [64];

  logic [3:0]  sa_w, sa_r;
  logic [5:0]  la_w, la_r;
  logic [31:0] sd_w, sd_r, ld_w, ld_r;
  logic        busy_w, busy_r, done_w, done_r;

  int checks = 0;
  int failures = 0;

  int          idx [2];
  bit          active [2];
  bit          done_pend [2];
  bit          launch_pend [2];
  bit          hold_v [2];
  logic [31:0] hold_iq [2];
  int          done_cnt [2];

  always #5 clk = ~clk;

  l_preamble_gen_if if_w ();
  l_preamble_gen_if if_r ();

  assign if_w.iq_ready = ready;
  assign if_r.iq_ready = ready;
  assign sd_w = stf_rom[sa_w];
  assign ld_w = ltf_rom[la_w];
  assign sd_r = stf_rom[sa_r];
  assign ld_r = ltf_rom[la_r];

  l_preamble_gen #(.WINDOW_EN(1'b1), .STF_REPS(10), .LTF_GI_LEN(32)) dut_w (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .stf_addr (sa_w),
    .stf_dout (sd_w),
    .ltf_addr (la_w),
    .ltf_dout (ld_w),
    .tx       (if_w),
    .busy     (busy_w),
    .done     (done_w)
  );

  l_preamble_gen #(.WINDOW_EN(1'b0), .STF_REPS(10), .LTF_GI_LEN(32)) dut_r (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .stf_addr (sa_r),
    .stf_dout (sd_r),
    .ltf_addr (la_r),
    .ltf_dout (ld_r),
    .tx       (if_r),
    .busy     (busy_r),
    .done     (done_r)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int floor_half(input int s);
    if (s >= 0) return s / 2;
    return -((-s + 1) / 2);
  endfunction

  function automatic logic [15:0] avg16(input logic [15:0] a, input logic [15:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    return 16'(floor_half(s));
  endfunction

  // Preamble sample n straight from the region rules: STF periods, LTF GI tail, LTF symbols.
  function automatic logic [31:0] exp_sample(input int n, input bit win);
    logic [31:0] raw, s0;
    if (n < 160)      raw = stf_rom[n % 16];
    else if (n < 192) raw = ltf_rom[n - 160 + 32];
    else              raw = ltf_rom[(n - 192) % 64];
    if (win && n == 0) return {avg16(raw[31:16], 16'h0), avg16(raw[15:0], 16'h0)};
    if (win && n == 160) begin
      s0 = stf_rom[0];
      return {avg16(s0[31:16], raw[31:16]), avg16(s0[15:0], raw[15:0])};
    end
    return raw;
  endfunction

  task automatic mon(input int d, input logic [31:0] iq, input logic v, input logic busy,
                     input logic done);
    bit was_active;
    was_active = active[d];
    chk($sformatf("done[%0d]", d), 32'(done), 32'(done_pend[d]));
    done_pend[d] = 1'b0;
    chk($sformatf("busy[%0d]", d), 32'(busy), 32'(was_active || start));
    if (!was_active) chk($sformatf("idle_valid[%0d]", d), 32'(v), 32'd0);
    if (launch_pend[d]) chk($sformatf("latency[%0d]", d), 32'(v), 32'd1);
    launch_pend[d] = 1'b0;
    if (hold_v[d]) begin
      chk($sformatf("hold_valid[%0d]", d), 32'(v), 32'd1);
      chk($sformatf("hold_iq[%0d]", d), iq, hold_iq[d]);
    end
    if (v && ready && was_active) begin
      chk($sformatf("sample[%0d] n=%0d", d, idx[d]), iq, exp_sample(idx[d], d == 1));
      idx[d]++;
      if (idx[d] == NTOT) begin
        idx[d]       = 0;
        active[d]    = 1'b0;
        done_pend[d] = 1'b1;
        done_cnt[d]++;
      end
    end
    hold_v[d]  = v && !ready;
    hold_iq[d] = iq;
    if (!was_active && start) begin
      active[d]      = 1'b1;
      launch_pend[d] = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      for (int d = 0; d < 2; d++) begin
        idx[d]         = 0;
        active[d]      = 1'b0;
        done_pend[d]   = 1'b0;
        launch_pend[d] = 1'b0;
        hold_v[d]      = 1'b0;
      end
    end else begin
      mon(0, if_r.iq, if_r.iq_valid, busy_r, done_r);
      mon(1, if_w.iq, if_w.iq_valid, busy_w, done_w);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit rnd);
    int base;
    base = done_cnt[1];
    for (int c = 0; c < 4000 && done_cnt[1] == base; c++) begin
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
    end
    ready = 1'b1;
    chk("preamble_completes", 32'(done_cnt[1] != base), 32'd1);
    repeat (3) tick();
  endtask

  initial begin
    int vcnt;
    for (int k = 0; k < 16; k++) stf_rom[k] = {16'(k * 1237 - 9000), 16'(3000 - k * 811)};
    for (int k = 0; k < 64; k++) ltf_rom[k] = {16'(k * 523 - 17000), 16'(12000 - k * 389)};
    stf_rom[0]  = 32'h01F6_01F6;
    stf_rom[1]  = 32'hFA59_001A;
    ltf_rom[32] = 32'h0400_FC00;
    for (int d = 0; d < 2; d++) done_cnt[d] = 0;
    rstn  = 1'b0;
    start = 1'b0;
    ready = 1'b1;
    repeat (3) tick();

    @(negedge clk);
    chk("rst_iq", if_w.iq, 32'h0);
    chk("rst_valid", 32'(if_w.iq_valid), 32'd0);
    chk("rst_busy", 32'(busy_w), 32'd0);
    chk("rst_done", 32'(done_w), 32'd0);
    chk("rst_valid_raw", 32'(if_r.iq_valid), 32'd0);

    chk("model_s0_win", exp_sample(0, 1'b1), 32'h00FB_00FB);
    chk("model_s1", exp_sample(1, 1'b1), 32'hFA59_001A);
    chk("model_s160_win", exp_sample(160, 1'b1), 32'h02FB_FEFB);
    chk("model_s0_raw", exp_sample(0, 1'b0), 32'h01F6_01F6);
    chk("model_s160_raw", exp_sample(160, 1'b0), 32'h0400_FC00);
    chk("model_s192", exp_sample(192, 1'b1), ltf_rom[0]);

    tick();
    rstn = 1'b1;
    tick();

    // Full preamble with ready held high.
    start = 1'b1;
    tick();
    start = 1'b0;
    vcnt = 0;
    for (int i = 0; i < NTOT; i++) begin
      @(negedge clk);
      if (if_w.iq_valid) vcnt++;
      if (i == 0) begin
        chk("dut_s0_win", if_w.iq, 32'h00FB_00FB);
        chk("dut_s0_raw", if_r.iq, 32'h01F6_01F6);
      end
      if (i == 1) chk("dut_s1", if_w.iq, 32'hFA59_001A);
      if (i == 160) begin
        chk("dut_s160_win", if_w.iq, 32'h02FB_FEFB);
        chk("dut_s160_raw", if_r.iq, 32'h0400_FC00);
      end
    end
    chk("consec_valid", 32'(vcnt), 32'd320);
    @(negedge clk);
    chk("done_pulse", 32'(done_w), 32'd1);
    repeat (3) tick();

    // Random backpressure.
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1'b1);

    // Extra starts mid-preamble are ignored; a start on the done cycle relaunches.
    ready = 1'b1;
    start = 1'b1;
    tick();
    for (int j = 1; j <= 320; j++) begin
      start = (j == 6 || j == 201);
      tick();
    end
    start = 1'b1;
    @(negedge clk);
    chk("done_with_start", 32'(done_w), 32'd1);
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("relaunch_valid", 32'(if_w.iq_valid), 32'd1);
    chk("relaunch_s0", if_w.iq, 32'h00FB_00FB);
    wait_done(1'b0);

    // Reset in the middle of a preamble aborts it.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (100) tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    @(negedge clk);
    chk("abort_valid", 32'(if_w.iq_valid), 32'd0);
    chk("abort_busy", 32'(busy_w), 32'd0);
    chk("abort_valid_raw", 32'(if_r.iq_valid), 32'd0);
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1'b0);

    chk("final_idle", 32'(busy_w), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l_preamble_gen.md
Name: l_preamble_gen

Overview:
Sequences the legacy 802.11a/g preamble into the TX sample stream: 160 L-STF samples, then 160 L-LTF samples (32-sample GI2 plus 2×64). Samples come from two external combinational ROMs: the L-STF ROM (16×32b) and the L-LTF ROM (64×32b).
Sits between the TX controller (start pulse) and the sample mux / IFFT-output merge that consumes a valid/ready IQ stream.
Optional edge windowing softens the preamble start and the STF→LTF transition.

Parameters:
WINDOW_EN, 1, enables windowing: halve sample 0; average the two sides at the STF→LTF boundary.
STF_REPS, 10, number of 16-sample L-STF periods.
LTF_GI_LEN, 32, length of the L-LTF guard interval, taken from the tail of the 64-sample symbol.

Ports:
clk  in  1  clock
rstn  in  1  reset; synchronous, active-low
start  in  1  single-cycle request to emit one preamble
stf_addr  out  4  L-STF ROM address (combinational)
stf_dout  in  32  L-STF ROM data, [31:16]=I, [15:0]=Q, signed 16b each
ltf_addr  out  6  L-LTF ROM address (combinational)
ltf_dout  in  32  L-LTF ROM data, same format
iq  out  32  output sample, [31:16]=I, [15:0]=Q
iq_valid  out  1  iq holds a valid sample
iq_ready  in  1  downstream accepts iq when iq_valid&iq_ready
busy  out  1  high from the start-accept cycle until the last sample is accepted
done  out  1  one-cycle pulse on the cycle after the last sample is accepted

Behaviour:
- Reset: all registers clear at the clk edge while rstn=0.
  - iq=0, iq_valid=0, busy=0, done=0.
  - State IDLE, index n=0.
  - Reset mid-preamble aborts immediately. No done pulse; partial stream is discarded by downstream.
- Sample index n runs 0..319 (N_TOT = 16*STF_REPS + LTF_GI_LEN + 128). ROM addresses are combinational from n:
  - Sample addressing by index range:
    - n < 160: stf_addr = n[3:0].
    - 160 ≤ n < 192: ltf_addr = n-160+32.
    - n ≥ 192: ltf_addr = (n-192) mod 64.
  - The unused address output holds 0.
- States: IDLE → STF → LTF_GI → LTF_SYM → IDLE.
  - Transitions occur when the last sample of each region is loaded into the output register.
- load = (state≠IDLE or start) and (!iq_valid or iq_ready).
  - On load: iq ← sample(n), iq_valid ← 1, n ← n+1.
  - When no sample remains after the last is accepted: iq_valid ← 0, state ← IDLE, done ← 1 for one cycle.
- Start latency: start in IDLE at cycle N gives iq_valid=1 with sample 0 at cycle N+1 (one register).
- Backpressure: while iq_valid & !iq_ready, iq, n and addresses hold stable. No sample is dropped or duplicated.
- start while busy=1 is ignored. start on the same cycle done=1 is accepted; state is IDLE then.
- Windowing (WINDOW_EN=1), applied per component:
  - n=0: I and Q each arithmetic-shifted right by 1 (floor).
  - n=160: the ROM reads both stf_addr=0 and ltf_addr=32 that cycle. Output is (stf+ltf)>>>1, computed with a 17-bit sum then floor shift, truncated back to 16b.
  - All other samples pass through unmodified.
- WINDOW_EN=0: all 320 samples are raw ROM words.

Decomposition:
- Shared package/include (openofdm_tx_pre_def.v): STF_LEN=16, LTF_LEN=64, state encodings, IQ field slice macros.
- Sub-module l_win_avg: combinational per-component halving/averaging, 2×16b in, 16b out.
- The ROMs stay external and are instantiated by the parent.

Test Plan:
1. Reset, then start with iq_ready=1 held, WINDOW_EN=1: sample 0 = 0x00FB_00FB; samples 1..159 = STF ROM[n%16] (e.g. n=1 → 0xFA59_001A); 320 consecutive valid cycles; done pulses once on the cycle after sample 319 is accepted.
2. Boundary check, with the bench LTF model ltf[32]=0x0400_FC00 and stf[0]=0x01F6_01F6: sample 160 = 0x02FB_FEFB. Samples 161..191 = ltf[33..63]; sample 192 = ltf[0].
3. Random iq_ready toggling (~50%): output sequence is identical to scenario 1; iq is stable whenever valid&!ready; busy stays high throughout.
4. Second start pulses at n=5 and n=200: ignored, exactly 320 samples emitted; start on the done cycle launches a new preamble one cycle later.
5. rstn=0 at n=100: next cycle iq_valid=0, busy=0, no done; a fresh start emits from sample 0.
6. WINDOW_EN=0: sample 0 = 0x01F6_01F6; sample 160 = ltf[32].
